// File: rtl/mux_pkg.sv
// Constants shared by the 2:1 selector stage and its combinational core.
package mux_pkg;

    localparam logic SEL_A             = 1'b0;
    localparam logic SEL_B             = 1'b1;
    localparam int   MUX_DEFAULT_WIDTH = 1;

endpackage : mux_pkg

// File: rtl/mux_2_1_core.sv
// Pure combinational 2:1 selector; feeds both the bypass output and the output register.
module mux_2_1_core
    import mux_pkg::*;
#(
    parameter int WIDTH = MUX_DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sel_i,
    output logic [WIDTH-1:0] y_o
);

    assign y_o = (sel_i == SEL_B) ? b_i : a_i;

endmodule : mux_2_1_core

// File: rtl/mux_2_1.sv
// Registered 2:1 selector with a single-entry valid/ready output stage and a zero-latency bypass.
module mux_2_1
    import mux_pkg::*;
#(
    parameter int WIDTH = MUX_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    input  logic             y_ready,
    output logic [WIDTH-1:0] y_comb
);

    logic [WIDTH-1:0] sel_data;
    logic [WIDTH-1:0] y_q, y_d;
    logic             y_valid_q, y_valid_d;
    logic             accept;

    mux_2_1_core #(.WIDTH(WIDTH)) u_core (
        .a_i   (a),
        .b_i   (b),
        .sel_i (sel),
        .y_o   (sel_data)
    );

    // Ready depends only on the output slot, never on in_valid, so no comb loop upstream.
    assign in_ready = !y_valid_q || y_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        y_d       = y_q;
        y_valid_d = y_valid_q;
        if (accept) begin
            y_d       = sel_data;
            y_valid_d = 1'b1;
        end else if (y_ready) begin
            y_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q       <= '0;
            y_valid_q <= 1'b0;
        end else begin
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
        end
    end

    assign y       = y_q;
    assign y_valid = y_valid_q;
    assign y_comb  = sel_data;

endmodule : mux_2_1

// File: tb/tb_mux_2_1.sv
// Directed bench: WIDTH=8 instance for the handshake, WIDTH=1 instance for the bypass truth table.
module tb_mux_2_1;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a, b;
    logic       sel, in_valid, y_ready;
    logic       in_ready;
    logic [7:0] y, y_comb;
    logic       y_valid;

    logic [0:0] a1, b1;
    logic       sel1, in_valid1;
    logic       in_ready1, y_valid1;
    logic [0:0] y1, y_comb1;

    int passes = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mux_2_1 #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .a(a), .b(b), .sel(sel), .in_valid(in_valid),
        .in_ready(in_ready), .y(y), .y_valid(y_valid), .y_ready(y_ready), .y_comb(y_comb)
    );

    mux_2_1 #(.WIDTH(1)) u1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .sel(sel1), .in_valid(in_valid1),
        .in_ready(in_ready1), .y(y1), .y_valid(y_valid1), .y_ready(y_ready), .y_comb(y_comb1)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] tt;
        tt = 8'b1100_1010;  // y_comb for {sel,b,a} = index

        // Reset held 2 cycles with a beat offered: reset must win
        rst = 1'b1; in_valid = 1'b1; a = 8'h3C; b = 8'hA5; sel = 1'b1; y_ready = 1'b1;
        a1 = '0; b1 = '0; sel1 = 1'b0; in_valid1 = 1'b0;
        tick();
        tick();
        chk("rst_y", y, 8'h00);
        chk("rst_vld", {7'b0, y_valid}, 8'h00);
        chk("rst_vld_w1", {7'b0, y_valid1}, 8'h00);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("rst_in_ready", {7'b0, in_ready}, 8'h01);

        // Bypass truth table: a toggles every 5ns, b every 10ns, sel every 20ns
        for (int i = 0; i < 20; i++) begin
            a1 = 1'(i % 2); b1 = 1'((i / 2) % 2); sel1 = 1'((i / 4) % 2);
            #1;
            chk($sformatf("bypass_%0d", i % 8), {7'b0, y_comb1}, {7'b0, tt[i % 8]});
            #4;
        end

        // Latency: one beat, visible exactly one edge later
        tick();
        a = 8'h3C; b = 8'hA5; sel = 1'b1; in_valid = 1'b1; y_ready = 1'b1;
        #1;
        chk("comb_w8", y_comb, 8'hA5);
        tick();
        chk("lat_y", y, 8'hA5);
        chk("lat_vld", {7'b0, y_valid}, 8'h01);
        in_valid = 1'b0;
        tick();
        chk("drain_vld", {7'b0, y_valid}, 8'h00);
        chk("drain_y_hold", y, 8'hA5);

        // Streaming: alternating select every cycle, no bubbles
        a = 8'h11; b = 8'h22; sel = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("stream_rdy_%0d", k), {7'b0, in_ready}, 8'h01);
            tick();
            chk($sformatf("stream_y_%0d", k), y, (k % 2 == 0) ? 8'h11 : 8'h22);
            chk($sformatf("stream_vld_%0d", k), {7'b0, y_valid}, 8'h01);
            sel = ~sel;
        end

        // Backpressure: y=22 held, new beat 33 waits
        a = 8'h33; sel = 1'b0; y_ready = 1'b0;
        #1;
        chk("bp_in_ready", {7'b0, in_ready}, 8'h00);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("bp_y_%0d", k), y, 8'h22);
            chk($sformatf("bp_vld_%0d", k), {7'b0, y_valid}, 8'h01);
            chk($sformatf("bp_rdy_%0d", k), {7'b0, in_ready}, 8'h00);
        end
        y_ready = 1'b1;
        #1;
        chk("bp_release_rdy", {7'b0, in_ready}, 8'h01);
        tick();
        chk("bp_accept_y", y, 8'h33);
        chk("bp_accept_vld", {7'b0, y_valid}, 8'h01);
        in_valid = 1'b0;
        tick();
        chk("bp_drain_vld", {7'b0, y_valid}, 8'h00);

        // Reset during a stall discards the held beat
        a = 8'h44; sel = 1'b0; in_valid = 1'b1; y_ready = 1'b0;
        tick();
        chk("stall_load_y", y, 8'h44);
        a = 8'h55;
        tick();
        chk("stall_hold_y", y, 8'h44);
        rst = 1'b1;
        tick();
        chk("midrst_y", y, 8'h00);
        chk("midrst_vld", {7'b0, y_valid}, 8'h00);
        rst = 1'b0; in_valid = 1'b0; y_ready = 1'b1;
        tick();
        chk("post_rst_vld", {7'b0, y_valid}, 8'h00);
        chk("post_rst_y", y, 8'h00);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule : tb_mux_2_1
